mem_access_ctrl: RTL and testbench

- Load/store access controller between the processor core's memory request port and the 4K x 32 single_port_ram.
- Converts byte-addressed byte/half/word loads and stores into word accesses of the synchronous RAM.
- Performs sign/zero extension on loads and read-modify-write for sub-word stores.
- Reports misaligned or illegal requests without touching the RAM.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/byte_lane_unit.sv | 41 ++++
 rtl/mem_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the load/store access controller and its byte-lane datapath.
package mem_pkg;

    localparam int RAM_ADDR_W = 12;
    localparam int RAM_DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_e;

    // Illegal size, odd half-word, or word not on a 4-byte boundary.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
        return (size == SZ_BAD) ||
               ((size == SZ_HALF) && lane[0]) ||
               ((size == SZ_WORD) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane steering: load extract/extend and sub-word store merge
// against the current RAM word, little-endian lane order.
module byte_lane_unit
    import mem_pkg::*;
(
    input  logic [31:0] ram_q,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        is_signed,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = 8'(ram_q >> {lane, 3'b000});
        half_sel   = lane[1] ? ram_q[31:16] : ram_q[15:0];
        load_data  = ram_q;
        store_data = wdata;
        case (size)
            SZ_BYTE: begin
                load_data  = {{24{is_signed & byte_sel[7]}}, byte_sel};
                store_data = ram_q;
                store_data[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data  = {{16{is_signed & half_sel[15]}}, half_sel};
                store_data = ram_q;
                store_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data  = ram_q;
                store_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store controller in front of a synchronous 4K x 32 RAM.
// Sub-word stores are read-modify-write; misaligned or illegal requests never reach the RAM.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    state_e            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    size_e             size_q, size_d;
    logic              we_q, we_d;
    logic              signed_q, signed_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              ram_we_q, ram_we_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] load_data, store_data;

    byte_lane_unit u_lanes (
        .ram_q      (ram_q),
        .wdata      (wdata_q),
        .lane       (lane_q),
        .size       (size_q),
        .is_signed  (signed_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        size_d       = size_q;
        we_d         = we_q;
        signed_d     = signed_q;
        wdata_d      = wdata_q;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        ram_we_d     = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    lane_d       = req_addr[1:0];
                    size_d       = size_e'(req_size);
                    we_d         = req_we;
                    signed_d     = req_signed;
                    wdata_d      = req_wdata;
                    ram_addr_d   = req_addr[ADDR_W+1:2];
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                    if (access_err(req_size, req_addr[1:0])) begin
                        resp_err_d   = 1'b1;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        // Full-word store needs no read of the old contents.
                        ram_data_d = req_wdata;
                        ram_we_d   = 1'b1;
                        state_d    = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: state_d = WAIT;
            WAIT: begin
                if (we_q) begin
                    ram_data_d = store_data;
                    ram_we_d   = 1'b1;
                    state_d    = WR;
                end else begin
                    resp_rdata_d = load_data;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            WR: begin
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            size_q       <= SZ_BYTE;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            wdata_q      <= '0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            ram_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            we_q         <= we_d;
            signed_q     <= signed_d;
            wdata_q      <= wdata_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            ram_we_q     <= ram_we_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign ram_data   = ram_data_q;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural RAM, reference memory image, and
// response/write scoreboards checked every falling edge.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [13:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_signed = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_data;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_q;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_data   (ram_data),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_q      (ram_q)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h0103_0507);
    endfunction

    // Behavioural synchronous RAM, filled once on the first edge.
    logic [31:0] mem [0:4095];
    logic        mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_data;
        end
        ram_q <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } resp_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          due;
    } wr_t;

    resp_t       exp_q[$];
    wr_t         wr_q[$];
    logic [31:0] ref_mem [0:4095];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor_step();
        resp_t r;
        wr_t   w;
        if (resp_valid === 1'b1) begin
            check_eq("resp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                check_eq("resp_rdata", resp_rdata, r.rdata);
                check_eq("resp_err", 32'(resp_err), 32'(r.err));
                check_eq("resp_cycle", 32'(cyc), 32'(r.due));
            end
        end
        if (ram_we === 1'b1) begin
            check_eq("write_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                w = wr_q.pop_front();
                check_eq("ram_addr", 32'(ram_addr), 32'(w.addr));
                check_eq("ram_data", ram_data, w.data);
                check_eq("write_cycle", 32'(cyc), 32'(w.due));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor_step();
    endtask

    // Waits for req_ready, presents the request and returns just after the accept edge
    // with req_valid still high; busy counts the falling edges seen with req_ready low.
    task automatic issue(input logic we, input logic [13:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata, input bit track,
                         output int busy);
        resp_t       r;
        wr_t         w;
        logic        err;
        logic [31:0] word, sh, m, merged;
        int          s;
        busy = 0;
        tick();
        while (req_ready !== 1'b1 && busy < 50) begin
            busy++;
            tick();
        end
        if (req_ready !== 1'b1) check_eq("req_ready_timeout", 32'(req_ready), 32'd1);
        req_we     = we;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        if (track) begin
            err  = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                   (size == 2'b10 && addr[1:0] != 2'b00);
            word = ref_mem[addr[13:2]];
            s    = 8 * int'(addr[1:0]);
            sh   = word >> s;
            r.err   = err;
            r.rdata = 32'h0;
            if (err) begin
                r.due = cyc + 1;
            end else if (!we) begin
                r.due = cyc + 3;
                case (size)
                    2'b00:   r.rdata = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
                    2'b01:   r.rdata = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
                    default: r.rdata = word;
                endcase
            end else begin
                m      = (size == 2'b00) ? 32'h0000_00FF :
                         (size == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
                m      = m << s;
                merged = (word & ~m) | ((wdata << s) & m);
                ref_mem[addr[13:2]] = merged;
                w.addr = addr[13:2];
                w.data = merged;
                w.due  = (size == 2'b10) ? cyc + 1 : cyc + 3;
                r.due  = (size == 2'b10) ? cyc + 2 : cyc + 4;
                wr_q.push_back(w);
            end
            exp_q.push_back(r);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        check_eq("drain_resp_q", 32'(exp_q.size()), 32'd0);
        check_eq("drain_wr_q", 32'(wr_q.size()), 32'd0);
        exp_q.delete();
        wr_q.delete();
    endtask

    task automatic one(input logic we, input logic [13:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wdata);
        int b;
        issue(we, addr, size, sgn, wdata, 1'b1, b);
        idle();
    endtask

    initial begin
        int b1, b2;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);

        repeat (3) tick();
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp_rdata", resp_rdata, 32'd0);
        check_eq("rst_resp_err", 32'(resp_err), 32'd0);
        check_eq("rst_ram_we", 32'(ram_we), 32'd0);
        check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
        check_eq("rst_ram_data", ram_data, 32'd0);
        rst_n = 1'b1;

        // Word store then word load.
        one(1'b1, 14'h008, 2'b10, 1'b0, 32'hDEAD_BEEF);
        one(1'b0, 14'h008, 2'b10, 1'b0, 32'h0);
        drain();
        check_eq("mem_w2_word_store", mem[2], 32'hDEAD_BEEF);

        // Sub-word loads with sign and zero extension.
        one(1'b0, 14'h00B, 2'b00, 1'b1, 32'h0);
        one(1'b0, 14'h00B, 2'b00, 1'b0, 32'h0);
        one(1'b0, 14'h00A, 2'b01, 1'b1, 32'h0);
        one(1'b0, 14'h008, 2'b00, 1'b0, 32'h0);
        drain();

        // Read-modify-write byte and half stores.
        one(1'b1, 14'h009, 2'b00, 1'b0, 32'h0000_0055);
        drain();
        check_eq("mem_w2_byte_store", mem[2], 32'hDEAD_55EF);
        one(1'b1, 14'h00A, 2'b01, 1'b0, 32'h0000_1234);
        drain();
        check_eq("mem_w2_half_store", mem[2], 32'h1234_55EF);
        one(1'b0, 14'h008, 2'b10, 1'b0, 32'h0);
        drain();

        // Misaligned and illegal requests.
        one(1'b0, 14'h006, 2'b10, 1'b0, 32'h0);
        one(1'b1, 14'h001, 2'b01, 1'b0, 32'hFFFF_FFFF);
        one(1'b1, 14'h004, 2'b11, 1'b0, 32'hFFFF_FFFF);
        drain();
        check_eq("mem_w0_after_err", mem[0], init_word(0));
        check_eq("mem_w1_after_err", mem[1], init_word(1));

        // Back-to-back loads with req_valid held high.
        issue(1'b0, 14'h008, 2'b10, 1'b0, 32'h0, 1'b1, b1);
        issue(1'b0, 14'h00A, 2'b01, 1'b1, 32'h0, 1'b1, b2);
        check_eq("b2b_first_busy", 32'(b1), 32'd0);
        check_eq("b2b_second_busy", 32'(b2), 32'd3);
        idle();
        drain();

        // Reset while a byte store sits in WAIT: no write, no response.
        issue(1'b1, 14'h008, 2'b00, 1'b0, 32'h0000_00AA, 1'b0, b1);
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("rst_mid_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
        repeat (4) tick();
        check_eq("mem_w2_after_reset", mem[2], 32'h1234_55EF);
        one(1'b0, 14'h008, 2'b10, 1'b0, 32'h0);
        drain();

        // Random mix over a few words, sometimes back-to-back.
        for (int i = 0; i < 60; i++) begin
            issue(1'($urandom_range(0, 1)), 14'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, 1'b1, b1);
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
        drain();
        for (int i = 0; i < 8; i++) check_eq("mem_final", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
